// File: rtl/neg_pkg.sv
// neg_pkg: shared constants for the negation-result collector.
//   DEF_WIDTH / DEF_DEPTH / DEF_ACC_W : default operand width, FIFO depth and
//                                       accumulator width.
//   ERR_CNT_W                         : width of the saturating error counter.
//   min_neg(w)                        : the non-negatable minimum value of a
//                                       w-bit two's complement word (MSB only).
package neg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ACC_W = 16;
  localparam int ERR_CNT_W = 8;

  // Only the MSB set: 0x80 at w = 8. Negating it yields itself.
  function automatic logic [63:0] min_neg(input int w);
    return 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/neg_fifo.sv
// neg_fifo: DEPTH-entry show-ahead FIFO with a separately tracked occupancy.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous flush; wins over push and pop
//   push, wdata       : write strobe and data (caller guarantees !full)
//   pop               : read strobe (caller guarantees !empty)
//   rdata             : head entry (valid only when !empty)
//   count             : occupancy 0..DEPTH
//   full, empty       : count == DEPTH / count == 0
module neg_fifo
  import neg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is reset too so the show-ahead output is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/neg_result_collector.sv
// neg_result_collector: consumes {ans1, ans2} pairs from the negation stage,
// queues ans1 for the next stage, keeps a signed running sum of ans1 and
// counts pairs whose ans2 is nonzero (a correct negator always gives 0).
// Optional feature macro: NEG_COLLECT_OVF_EN (counts pushes of the
// non-negatable minimum value on ovf_cnt; tied to 0 when undefined).
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   clr                  : synchronous clear of FIFO, sum and error state
//   in_valid/in_ready    : upstream handshake; in_ans1, in_ans2 payload
//   out_valid/out_ready  : downstream handshake; out_data = head entry
//   count                : FIFO occupancy
//   acc                  : running sum of sign-extended ans1 (wraps)
//   err_cnt, err_flag    : saturating error count, sticky error flag
//   ovf_cnt              : saturating count of minimum-value pushes
//
// Handshake: a transfer happens on a rising edge where valid && ready were
// both high during the preceding cycle; valid does not depend on ready, and
// the sender holds valid and payload stable until the transfer.
module neg_result_collector
  import neg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_ans1,
  input  logic [WIDTH-1:0]       in_ans2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [ACC_W-1:0]       acc,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic                   err_flag,
  output logic [ERR_CNT_W-1:0]   ovf_cnt
);

  logic full, empty, push, pop;

  // reset gates in_ready so nothing is offered as acceptable while held low.
  assign in_ready  = reset && !full && !clr;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  // A pop coinciding with clr is not a transfer.
  assign pop       = out_valid && out_ready && !clr;

  neg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr),
    .push  (push),
    .wdata (in_ans1),
    .pop   (pop),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_flag_q, err_flag_d;

  always_comb begin
    acc_d      = acc_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clr) begin
      acc_d      = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (push) begin
      acc_d = acc_q + {{(ACC_W-WIDTH){in_ans1[WIDTH-1]}}, in_ans1};
      if (in_ans2 != '0) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign acc      = acc_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;

`ifdef NEG_COLLECT_OVF_EN
  localparam logic [WIDTH-1:0] MIN_NEG_W = WIDTH'(min_neg(WIDTH));

  logic [ERR_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr) begin
      ovf_cnt_d = '0;
    end else if (push && (in_ans1 == MIN_NEG_W) && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_neg_result_collector.sv
module tb_neg_result_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int ACC_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_ans1 = '0;
  logic [WIDTH-1:0] in_ans2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic [ACC_W-1:0] acc;
  logic [7:0]       err_cnt;
  logic             err_flag;
  logic [7:0]       ovf_cnt;

  neg_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ans1   (in_ans1),
    .in_ans2   (in_ans2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .acc       (acc),
    .err_cnt   (err_cnt),
    .err_flag  (err_flag),
    .ovf_cnt   (ovf_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of words the collector should hold, plus plain integer bookkeeping.
  logic [WIDTH-1:0] exp_q[$];
  int m_acc = 0;
  int m_err = 0;
  int m_ovf = 0;

  task automatic model_clear();
    exp_q.delete();
    m_acc = 0;
    m_err = 0;
    m_ovf = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // At each falling edge: compare the DUT to the model, then advance the
  // model by what the next rising edge will do.
  always @(negedge clk) begin
    logic exp_ready;
    logic [31:0] acc_w;
    if (!reset) begin
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_err_flag", 32'(err_flag), 0);
      chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
      model_clear();
    end else begin
      exp_ready = (exp_q.size() < DEPTH) && !clr;
      acc_w = 32'(m_acc);
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("acc", 32'(acc), {16'h0, acc_w[15:0]});
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("err_flag", 32'(err_flag), 32'(m_err != 0));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
      if (clr) begin
        model_clear();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_ready) begin
          exp_q.push_back(in_ans1);
          m_acc = (m_acc + int'($signed(in_ans1))) % 65536;
          if (in_ans2 != 0 && m_err < 255) m_err++;
          else if (in_ans2 != 0) m_err = 255;
`ifdef NEG_COLLECT_OVF_EN
          if (in_ans1 == 8'h80 && m_ovf < 255) m_ovf++;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one pair and hold it until accepted (bounded wait).
  task automatic push_pair(input logic [7:0] a1, input logic [7:0] a2);
    bit done = 0;
    in_valid = 1'b1;
    in_ans1 = a1;
    in_ans2 = a2;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_accepted expected=accepted @%0t", $time);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit taken;

    // Reset held for 3 cycles, then released.
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Basic push then drain.
    out_ready = 1'b0;
    push_pair(8'hFB, 8'h00);
    push_pair(8'h05, 8'h00);
    @(negedge clk);
    chk("basic_head", 32'(out_data), 32'h FB);
    chk("basic_acc", 32'(acc), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(3);
    out_ready = 1'b0;

    // Fill, then valid and ready together while full.
    for (int i = 0; i < 4; i++) push_pair(8'(i + 1), 8'h00);
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ans1 = 8'h55; in_ans2 = 8'h00;
    out_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("pop_on_full_count", 32'(count), 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("push_pop_count", 32'(count), 3);
    @(posedge clk); #1;
    cycles(6);

    // Error path with saturation; drain continuously.
    do_clr();
    push_pair(8'h10, 8'h01);
    push_pair(8'h20, 8'h00);
    for (int i = 0; i < 300; i++) push_pair(8'($urandom_range(0, 255)), 8'hFF);
    @(negedge clk);
    chk("err_sat", 32'(err_cnt), 255);
    chk("err_sticky", 32'(err_flag), 1);
    @(posedge clk); #1;

    // Accumulator sign extension and wrap with the minimum value.
    do_clr();
    for (int i = 0; i < 300; i++) push_pair(8'h80, 8'h00);
    @(negedge clk);
    chk("acc_wrap", 32'(acc), 32'h6A00);
`ifdef NEG_COLLECT_OVF_EN
    chk("ovf_sat", 32'(ovf_cnt), 255);
`else
    chk("ovf_off", 32'(ovf_cnt), 0);
`endif
    @(posedge clk); #1;
    cycles(4);

    // clr with a concurrent offer: the offer is dropped.
    do_clr();
    out_ready = 1'b0;
    push_pair(8'h10, 8'h00);
    push_pair(8'h02, 8'h00);
    @(negedge clk);
    chk("pre_clr_acc", 32'(acc), 32'h0012);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ans1 = 8'h33; clr = 1'b1;
    cycles(1);
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_count", 32'(count), 0);
    chk("clr_acc", 32'(acc), 0);
    @(posedge clk); #1;

    // Randomized traffic with occasional clr.
    taken = 1;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || taken) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_ans1 = 8'($urandom_range(0, 255));
        in_ans2 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr = 1'b0;

    // Async reset mid-stream: outputs clear before any clock edge.
    out_ready = 1'b0;
    push_pair(8'h7F, 8'h01);
    push_pair(8'h01, 8'h00);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_acc", 32'(acc), 0);
    chk("async_err_flag", 32'(err_flag), 0);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    push_pair(8'hFF, 8'h00);
    out_ready = 1'b1;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
